// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter in front of a single-ported data memory.
//            Port 0 is the CPU, port 1 the loader/debug port. One access is
//            performed per ACCESS cycle; reads return registered data one
//            cycle after the grant.
// Ports    : clk                 - clock, rising edge
//            reset               - asynchronous active-low reset
//            req0/req1           - access requests
//            we0/we1             - 1 = write, 0 = read
//            addr0/addr1         - word addresses
//            wdata0/wdata1       - write data
//            gnt0/gnt1           - grant pulse, access happens this cycle
//            rvalid0/rvalid1     - read-data-valid pulse
//            rdata0/rdata1       - read data (held until next read of port)
//            mem_w_en            - memory write enable
//            mem_addr            - memory address (read and write)
//            mem_wdata           - memory write data
//            mem_rdata           - memory read data, combinational from addr
// Options  : DMEM_ARB_RR_EN defined   -> round-robin arbitration
//            DMEM_ARB_RR_EN undefined -> fixed priority, port 0 wins
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_ACCESS = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              r_port;      // port owning the current ACCESS cycle
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_rvalid0;
    logic              r_rvalid1;
`ifdef DMEM_ARB_RR_EN
    logic              r_ptr;       // port favoured on a tie
`endif

    logic              w_access;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_any;
    logic              w_win;

    // ------------------------------------------------------------------------
    // Next-state, arbitration and memory-side outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_access    = (r_state == c_ST_ACCESS);
        // The port being served right now is masked for this edge, which
        // makes a lone continuous requester get every other cycle and two
        // continuous requesters alternate.
        w_elig0     = req0 & ~(w_access & ~r_port);
        w_elig1     = req1 & ~(w_access &  r_port);
        w_any       = w_elig0 | w_elig1;
        w_win       = 1'b0;
        w_state_nxt = c_ST_IDLE;

`ifdef DMEM_ARB_RR_EN
        if (w_elig0 && w_elig1) begin
            w_win = r_ptr;
        end else begin
            w_win = w_elig1;
        end
`else
        w_win = ~w_elig0;
`endif

        if (w_any) begin
            w_state_nxt = c_ST_ACCESS;
        end

        gnt0      = w_access & ~r_port;
        gnt1      = w_access &  r_port;
        mem_w_en  = w_access & r_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_access) begin
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // State, latched request and read-return registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            r_ptr     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_any) begin
                r_port  <= w_win;
                r_we    <= w_win ? we1    : we0;
                r_addr  <= w_win ? addr1  : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
`ifdef DMEM_ARB_RR_EN
                r_ptr   <= ~w_win;
`endif
            end

            // Read data is captured at the edge that ends the access.
            r_rvalid0 <= w_access & ~r_we & ~r_port;
            r_rvalid1 <= w_access & ~r_we &  r_port;
            if (w_access && !r_we) begin
                if (r_port) begin
                    r_rdata1 <= mem_rdata;
                end else begin
                    r_rdata0 <= mem_rdata;
                end
            end
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule
`default_nettype wire
